// File: rtl/filter_pkg.sv
// -----------------------------------------------------------------------------
// filter_pkg
// Shared constants and helpers for the bitstream decimation filter.
//   OUT_W          : width of the decimated output sample (fixed at 8)
//   DECIM_DEFAULT  : default number of input bits per output sample
//   clog2()        : constant function used to size the phase counter
// -----------------------------------------------------------------------------
package filter_pkg;

  localparam int OUT_W         = 8;
  localparam int DECIM_DEFAULT = 255;

  // Number of bits needed to hold values 0..v-1 (0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    for (int i = 0; i < 32; i++) begin
      if (x > 0) begin
        r++;
        x = x >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/filter_accum.sv
// -----------------------------------------------------------------------------
// filter_accum
// Integrate-and-dump counter over contiguous windows of DECIM input bits.
// Parameters:
//   DECIM : input bits per window, legal range 2..255
// Ports:
//   CLK   in   clock, rising edge
//   RST   in   asynchronous active-high reset (clears phase and accumulator)
//   IN    in   serial bitstream, one bit per clock
//   cnt   out  running count of ones including the current bit (acc + IN)
//   dump  out  high during the last bit of each window; cnt is then the
//              complete window count
// -----------------------------------------------------------------------------
module filter_accum
  import filter_pkg::*;
#(
  parameter int DECIM = DECIM_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN,
  output logic [OUT_W-1:0] cnt,
  output logic             dump
);

  localparam int PH_W = (clog2(DECIM) < 1) ? 1 : clog2(DECIM);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

  logic [PH_W-1:0]  ph_p0;
  logic [OUT_W-1:0] acc_p0;

  // DECIM <= 255 keeps acc + IN inside 8 bits, so no carry is needed.
  assign cnt  = acc_p0 + {{(OUT_W-1){1'b0}}, IN};
  assign dump = (ph_p0 == PH_LAST);

  // ---- stage p0: phase counter and accumulator ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ph_p0  <= '0;
      acc_p0 <= '0;
    end else if (dump) begin
      ph_p0  <= '0;
      acc_p0 <= '0;
    end else begin
      ph_p0  <= ph_p0 + 1'b1;
      acc_p0 <= cnt;
    end
  end

endmodule

// File: rtl/filter.sv
// -----------------------------------------------------------------------------
// filter
// Bitstream filter and decimator: sinc1 (integrate-and-dump) over windows of
// DECIM input bits, producing one 8-bit sample per window. The sample is
// registered on the edge that samples the last bit of a window and held until
// the next window completes.
// Parameters:
//   DECIM : input bits per output sample, 2..255
//   OUT_W : output width, must be 8
// Ports:
//   CLK   in   clock, rising edge
//   RST   in   asynchronous active-high reset (OUT=0, partial window dropped)
//   IN    in   serial bitstream, sampled every rising edge
//   OUT   out  most recent decimated sample
// Build option:
//   FILTER_AVG2_EN : when defined, OUT is the 2-tap average of the current
//                    and previous window counts, (cnt + prev) >> 1.
// -----------------------------------------------------------------------------
module filter
  import filter_pkg::*;
#(
  parameter int DECIM = DECIM_DEFAULT,
  parameter int OUT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN,
  output logic [OUT_W-1:0] OUT
);

  if (OUT_W != filter_pkg::OUT_W) begin : g_bad_out_w
    $error("filter: OUT_W must be 8");
  end
  if (DECIM < 2 || DECIM > 255) begin : g_bad_decim
    $error("filter: DECIM must be in 2..255");
  end

  logic [OUT_W-1:0] cnt_p0;
  logic             dump_p0;

  filter_accum #(
    .DECIM (DECIM)
  ) u_accum (
    .CLK  (CLK),
    .RST  (RST),
    .IN   (IN),
    .cnt  (cnt_p0),
    .dump (dump_p0)
  );

`ifdef FILTER_AVG2_EN
  logic [OUT_W-1:0] prev_p1;

  // Mean of two window counts; the 9-bit sum is truncated, not rounded.
  function automatic logic [OUT_W-1:0] avg2(input logic [OUT_W-1:0] a,
                                            input logic [OUT_W-1:0] b);
    logic [OUT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[OUT_W:1];
  endfunction

  // ---- stage p1: averaged output and previous-count register ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT     <= '0;
      prev_p1 <= '0;
    end else if (dump_p0) begin
      OUT     <= avg2(cnt_p0, prev_p1);
      prev_p1 <= cnt_p0;
    end
  end
`else
  // ---- stage p1: output register ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT <= '0;
    end else if (dump_p0) begin
      OUT <= cnt_p0;
    end
  end
`endif

endmodule

// File: tb/tb_filter.sv
module tb_filter;

  localparam int D = 255;

  logic       clk;
  logic       rst;
  logic       in_bit;
  logic [7:0] out;

  int total = 0;
  int bad   = 0;

  filter #(
    .DECIM (D),
    .OUT_W (8)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .IN  (in_bit),
    .OUT (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {PZERO, PONE, PALT1, PALT0, PFIRST64, PLAST1} pat_t;

  typedef struct {
    pat_t       pat;
    logic [7:0] exp_plain;
    logic [7:0] exp_avg;
    string      name;
  } vec_t;

  vec_t vecs[8];

  function automatic logic pat_bit(pat_t p, int i);
    case (p)
      PZERO:    return 1'b0;
      PONE:     return 1'b1;
      PALT1:    return (i % 2) == 0;
      PALT0:    return (i % 2) == 1;
      PFIRST64: return i < 64;
      PLAST1:   return i == D - 1;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] pick(logic [7:0] plain, logic [7:0] avg);
`ifdef FILTER_AVG2_EN
    return avg;
`else
    return plain;
`endif
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one bit, take the rising edge, settle just after it.
  task automatic step(input logic b);
    in_bit = b;
    @(posedge clk);
    #1;
  endtask

  // Run one full window, checking hold before completion and the new value on it.
  task automatic run_window(input pat_t p, input logic [7:0] held,
                            input logic [7:0] exp, input string name);
    for (int i = 0; i < D; i++) begin
      step(pat_bit(p, i));
      if (i == 0)     check({name, " hold first"}, out, held);
      if (i == D - 2) check({name, " hold last"}, out, held);
      if (i == D - 1) check({name, " result"}, out, exp);
    end
  endtask

  logic [7:0] held;
  logic [7:0] e;

  initial begin
    vecs[0] = '{PZERO,    8'd0,   8'd0,   "zeros"};
    vecs[1] = '{PONE,     8'd255, 8'd127, "ones"};
    vecs[2] = '{PALT1,    8'd128, 8'd191, "alt from 1"};
    vecs[3] = '{PALT0,    8'd127, 8'd127, "alt from 0"};
    vecs[4] = '{PFIRST64, 8'd64,  8'd95,  "first64"};
    vecs[5] = '{PZERO,    8'd0,   8'd32,  "zeros2"};
    vecs[6] = '{PLAST1,   8'd1,   8'd0,   "last bit one"};
    vecs[7] = '{PONE,     8'd255, 8'd128, "ones2"};

    rst    = 1'b1;
    in_bit = 1'b0;
    #3;
    check("reset async", out, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset held", out, 8'd0);
    rst = 1'b0;

    held = 8'd0;
    for (int v = 0; v < 8; v++) begin
      e = pick(vecs[v].exp_plain, vecs[v].exp_avg);
      run_window(vecs[v].pat, held, e, vecs[v].name);
      held = e;
    end

    // Reset in the middle of a window of ones: partial count discarded.
    for (int i = 0; i < 100; i++) step(1'b1);
    check("midwin hold", out, held);
    #2 rst = 1'b1;
    #1;
    check("midwin reset immediate", out, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midwin reset held", out, 8'd0);
    rst = 1'b0;
    run_window(PONE, 8'd0, pick(8'd255, 8'd127), "after midwin reset");
    held = pick(8'd255, 8'd127);

    // Reset coinciding with a window-completion edge wins.
    for (int i = 0; i < D - 1; i++) step(1'b1);
    check("pre-complete hold", out, held);
    in_bit = 1'b1;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    check("reset at completion", out, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Zeros then ones then ones: exercises the averaging history from reset.
    run_window(PZERO, 8'd0, 8'd0, "post reset zeros");
    run_window(PONE, 8'd0, pick(8'd255, 8'd127), "post reset ones");
    run_window(PONE, pick(8'd255, 8'd127), 8'd255, "post reset ones2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
